// File: rtl/infix_to_postfix_stream_if.sv
// Character-stream bus between a character source and the infix->postfix converter.
// The master drives characters in and receives the postfix stream and error pulse.
interface infix_to_postfix_stream_if #(
    parameter int DATA_W = 8
);
    logic              load;
    logic [DATA_W-1:0] infix;
    logic              ready;
    logic [DATA_W-1:0] postfix;
    logic              err;

    modport master (output load, infix, input ready, postfix, err);
    modport slave  (input load, infix, output ready, postfix, err);
endinterface

// File: rtl/infix_to_postfix_stream.sv
// Streaming infix->postfix converter (shunting-yard). Buffers one expression burst,
// converts it with an operator stack one step per cycle, then streams the postfix form.
// Unbalanced parentheses, input overflow and stack overflow end in a one-cycle err pulse.
module infix_to_postfix_stream #(
    parameter int DATA_W      = 8,
    parameter int MAX_LEN     = 32,
    parameter int STACK_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    infix_to_postfix_stream_if.slave bus
);
    localparam int CNT_W  = $clog2(MAX_LEN + 1);
    localparam int IDX_W  = $clog2(MAX_LEN);
    localparam int SP_W   = $clog2(STACK_DEPTH + 1);
    localparam int SIDX_W = $clog2(STACK_DEPTH);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LEN);
    localparam logic [SP_W-1:0]  STK_FULL = SP_W'(STACK_DEPTH);

    localparam logic [DATA_W-1:0] CH_ADD = DATA_W'(8'h2B);
    localparam logic [DATA_W-1:0] CH_SUB = DATA_W'(8'h2D);
    localparam logic [DATA_W-1:0] CH_MUL = DATA_W'(8'h2A);
    localparam logic [DATA_W-1:0] CH_DIV = DATA_W'(8'h2F);
    localparam logic [DATA_W-1:0] CH_POW = DATA_W'(8'h5E);
    localparam logic [DATA_W-1:0] CH_LP  = DATA_W'(8'h28);
    localparam logic [DATA_W-1:0] CH_RP  = DATA_W'(8'h29);

    typedef enum logic [2:0] {IDLE, LOAD, CONV, FLUSH, OUT, ERR} state_t;

    function automatic logic is_op(input logic [DATA_W-1:0] c);
        return (c == CH_ADD) || (c == CH_SUB) || (c == CH_MUL) || (c == CH_DIV) || (c == CH_POW);
    endfunction

    function automatic logic [1:0] prec(input logic [DATA_W-1:0] c);
        if (c == CH_POW) return 2'd3;
        else if ((c == CH_MUL) || (c == CH_DIV)) return 2'd2;
        else return 2'd1;
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]  in_idx_q, in_idx_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]  out_idx_q, out_idx_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] in_buf_q  [MAX_LEN];
    logic [DATA_W-1:0] out_buf_q [MAX_LEN];
    logic [DATA_W-1:0] stk_q     [STACK_DEPTH];

    logic              in_we, out_we, stk_we;
    logic [IDX_W-1:0]  in_waddr, out_waddr;
    logic [SIDX_W-1:0] stk_waddr;
    logic [DATA_W-1:0] in_wdata, out_wdata, stk_wdata;

    logic [SP_W-1:0]   sp_m1;
    logic [DATA_W-1:0] cur_ch, top_ch;
    logic              pop_for_op;

    assign sp_m1  = sp_q - SP_W'(1);
    assign cur_ch = in_buf_q[in_idx_q[IDX_W-1:0]];
    assign top_ch = stk_q[sp_m1[SIDX_W-1:0]];
    // Stacked operator must leave first if it binds tighter, or equally tight for left-assoc input.
    assign pop_for_op = (sp_q != '0) && is_op(top_ch) &&
                        ((prec(top_ch) > prec(cur_ch)) ||
                         ((prec(top_ch) == prec(cur_ch)) && (cur_ch != CH_POW)));

    // State and control registers; reset clears control only, buffer contents are don't-care.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            in_idx_q  <= '0;
            out_cnt_q <= '0;
            out_idx_q <= '0;
            sp_q      <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            in_idx_q  <= in_idx_d;
            out_cnt_q <= out_cnt_d;
            out_idx_q <= out_idx_d;
            sp_q      <= sp_d;
            ovf_q     <= ovf_d;
        end
    end

    // Buffer and stack write ports.
    always_ff @(posedge clk) begin
        if (in_we)  in_buf_q[in_waddr]  <= in_wdata;
        if (out_we) out_buf_q[out_waddr] <= out_wdata;
        if (stk_we) stk_q[stk_waddr]     <= stk_wdata;
    end

    // Next-state and datapath step: one char consumed or one operator popped per cycle.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        in_idx_d  = in_idx_q;
        out_cnt_d = out_cnt_q;
        out_idx_d = out_idx_q;
        sp_d      = sp_q;
        ovf_d     = ovf_q;
        in_we     = 1'b0;
        in_waddr  = in_cnt_q[IDX_W-1:0];
        in_wdata  = bus.infix;
        out_we    = 1'b0;
        out_waddr = out_cnt_q[IDX_W-1:0];
        out_wdata = cur_ch;
        stk_we    = 1'b0;
        stk_waddr = sp_q[SIDX_W-1:0];
        stk_wdata = cur_ch;
        unique case (state_q)
            IDLE: begin
                if (bus.load) begin
                    in_we    = 1'b1;
                    in_waddr = '0;
                    in_cnt_d = CNT_W'(1);
                    ovf_d    = 1'b0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (bus.load) begin
                    if (in_cnt_q < MAX_CNT) begin
                        in_we    = 1'b1;
                        in_cnt_d = in_cnt_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    in_idx_d  = '0;
                    out_cnt_d = '0;
                    sp_d      = '0;
                    state_d   = ovf_q ? ERR : CONV;
                end
            end
            CONV: begin
                if (in_idx_q == in_cnt_q) begin
                    state_d = FLUSH;
                end else if (cur_ch == CH_LP) begin
                    if (sp_q == STK_FULL) begin
                        state_d = ERR;
                    end else begin
                        stk_we   = 1'b1;
                        sp_d     = sp_q + SP_W'(1);
                        in_idx_d = in_idx_q + CNT_W'(1);
                    end
                end else if (cur_ch == CH_RP) begin
                    if (sp_q == '0) begin
                        state_d = ERR;
                    end else if (top_ch == CH_LP) begin
                        sp_d     = sp_m1;
                        in_idx_d = in_idx_q + CNT_W'(1);
                    end else begin
                        out_we    = 1'b1;
                        out_wdata = top_ch;
                        out_cnt_d = out_cnt_q + CNT_W'(1);
                        sp_d      = sp_m1;
                    end
                end else if (is_op(cur_ch)) begin
                    if (pop_for_op) begin
                        out_we    = 1'b1;
                        out_wdata = top_ch;
                        out_cnt_d = out_cnt_q + CNT_W'(1);
                        sp_d      = sp_m1;
                    end else if (sp_q == STK_FULL) begin
                        state_d = ERR;
                    end else begin
                        stk_we   = 1'b1;
                        sp_d     = sp_q + SP_W'(1);
                        in_idx_d = in_idx_q + CNT_W'(1);
                    end
                end else begin
                    out_we    = 1'b1;
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                    in_idx_d  = in_idx_q + CNT_W'(1);
                end
            end
            FLUSH: begin
                if (sp_q == '0) begin
                    out_idx_d = '0;
                    state_d   = (out_cnt_q == '0) ? IDLE : OUT;
                end else if (top_ch == CH_LP) begin
                    state_d = ERR;
                end else begin
                    out_we    = 1'b1;
                    out_wdata = top_ch;
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                    sp_d      = sp_m1;
                end
            end
            OUT: begin
                out_idx_d = out_idx_q + CNT_W'(1);
                if (CNT_W'(out_idx_q + CNT_W'(1)) == out_cnt_q) state_d = IDLE;
            end
            ERR: begin
                in_cnt_d  = '0;
                out_cnt_d = '0;
                sp_d      = '0;
                ovf_d     = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        bus.ready   = (state_q == OUT);
        bus.postfix = (state_q == OUT) ? out_buf_q[out_idx_q[IDX_W-1:0]] : '0;
        bus.err     = (state_q == ERR);
    end
endmodule

// File: tb/tb_infix_to_postfix_stream.sv
// Directed bench for infix_to_postfix_stream: conversions, associativity, error cases, reset mid-output.
module tb_infix_to_postfix_stream;
    localparam int DATA_W      = 8;
    localparam int MAX_LEN     = 8;
    localparam int STACK_DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    infix_to_postfix_stream_if #(.DATA_W(DATA_W)) bus ();

    infix_to_postfix_stream #(
        .DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            chk($sformatf("%s.ready_in_load%0d", s, i), {31'b0, bus.ready}, 32'd0);
            bus.load  = 1'b1;
            bus.infix = s[i];
        end
        @(negedge clk);
        bus.load  = 1'b0;
        bus.infix = 8'h00;
    endtask

    task automatic wait_ready(input string s);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.ready && !bus.err && cyc < 40);
        chk($sformatf("%s.ready_rise", s), {31'b0, bus.ready}, 32'd1);
    endtask

    task automatic expect_out(input string s, input string exp);
        send(s);
        wait_ready(s);
        for (int i = 0; i < exp.len(); i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("%s.ready%0d", s, i), {31'b0, bus.ready}, 32'd1);
            chk($sformatf("%s.char%0d", s, i), {24'b0, bus.postfix}, {24'b0, exp[i]});
        end
        @(negedge clk);
        chk($sformatf("%s.ready_end", s), {31'b0, bus.ready}, 32'd0);
        chk($sformatf("%s.postfix_end", s), {24'b0, bus.postfix}, 32'd0);
        chk($sformatf("%s.err_end", s), {31'b0, bus.err}, 32'd0);
    endtask

    task automatic expect_err(input string s);
        int cyc;
        logic saw_ready;
        cyc = 0;
        saw_ready = 1'b0;
        send(s);
        do begin
            @(negedge clk);
            cyc++;
            if (bus.ready) saw_ready = 1'b1;
        end while (!bus.err && cyc < 40);
        chk($sformatf("%s.err_pulse", s), {31'b0, bus.err}, 32'd1);
        chk($sformatf("%s.no_ready", s), {31'b0, saw_ready}, 32'd0);
        @(negedge clk);
        chk($sformatf("%s.err_drop", s), {31'b0, bus.err}, 32'd0);
        chk($sformatf("%s.ready_after_err", s), {31'b0, bus.ready}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        bus.load  = 1'b0;
        bus.infix = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset.ready", {31'b0, bus.ready}, 32'd0);
        chk("reset.postfix", {24'b0, bus.postfix}, 32'd0);
        chk("reset.err", {31'b0, bus.err}, 32'd0);
        reset = 1'b0;

        expect_out("a+b*c", "abc*+");
        expect_out("(a+b)*c", "ab+c*");
        expect_out("a^b^c", "abc^^");
        expect_out("a-b-c", "ab-c-");
        expect_out("a*b/c", "ab*c/");
        expect_out("a+", "a+");
        expect_err("(a+b");
        expect_out("x", "x");
        expect_err("a+b)");
        expect_err("abcdefghi");
        expect_err("(((((");

        // Reset pulse in the middle of an output burst aborts it.
        send("a+b*c");
        wait_ready("a+b*c.mid");
        chk("mid.char0", {24'b0, bus.postfix}, 32'h61);
        @(negedge clk);
        chk("mid.char1", {24'b0, bus.postfix}, 32'h62);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid.ready_after_reset", {31'b0, bus.ready}, 32'd0);
        chk("mid.postfix_after_reset", {24'b0, bus.postfix}, 32'd0);
        @(negedge clk);
        chk("mid.ready_idle", {31'b0, bus.ready}, 32'd0);
        expect_out("a*b", "ab*");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
